// File: rtl/connect4_pkg.sv
// Shared codes and constants for the Connect4 move sequencer and board store.
package connect4_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam logic [1:0] RES_CONT = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLACE,
      S_SCAN,
      S_REPORT
   } state_t;

   // Scan order: horizontal, vertical, diagonal up-right, diagonal down-right.
   localparam logic [1:0] DIR_H  = 2'd0;
   localparam logic [1:0] DIR_V  = 2'd1;
   localparam logic [1:0] DIR_UR = 2'd2;
   localparam logic [1:0] DIR_DN = 2'd3;

   function automatic logic signed [4:0] dir_dc(input logic [1:0] d);
      return (d == DIR_V) ? 5'sd0 : 5'sd1;
   endfunction

   function automatic logic signed [4:0] dir_dr(input logic [1:0] d);
      logic signed [4:0] v;
      case (d)
         DIR_H:   v = 5'sd0;
         DIR_V:   v = 5'sd1;
         DIR_UR:  v = 5'sd1;
         default: v = -5'sd1;
      endcase
      return v;
   endfunction

   function automatic logic [1:0] player_code(input logic t);
      return t ? CELL_P2 : CELL_P1;
   endfunction

endpackage

// File: rtl/connect4_board.sv
// Board store: cells, per-column fill heights, drop-write port, scan and display
// read ports (combinational, 00 outside the board), synchronous clear.
module connect4_board
   import connect4_pkg::*;
#(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic [2:0] i_q_col,
   output logic [2:0] o_q_hgt,
   output logic       o_q_full,
   input  logic       i_wr_en,
   input  logic [2:0] i_wr_col,
   input  logic [1:0] i_wr_code,
   input  logic [2:0] i_sc_col,
   input  logic [2:0] i_sc_row,
   output logic [1:0] o_sc_cell,
   input  logic [2:0] i_rd_col,
   input  logic [2:0] i_rd_row,
   output logic [1:0] o_rd_cell
);
   localparam logic [3:0] C_COLS = 4'(COLS);
   localparam logic [3:0] C_ROWS = 4'(ROWS);

   logic [1:0] r_cell [COLS][ROWS];
   logic [2:0] r_hgt  [COLS];
   logic [2:0] w_wr_hgt;
   logic       w_wr_ok;

   function automatic logic [1:0] cell_at(input logic [2:0] c, input logic [2:0] r);
      if (({1'b0, c} < C_COLS) && ({1'b0, r} < C_ROWS)) return r_cell[c][r];
      return CELL_EMPTY;
   endfunction

   // Out-of-range columns report as full so they are rejected like a full column.
   function automatic logic [2:0] hgt_at(input logic [2:0] c);
      if ({1'b0, c} < C_COLS) return r_hgt[c];
      return C_ROWS[2:0];
   endfunction

   assign o_q_hgt   = hgt_at(i_q_col);
   assign o_q_full  = ({1'b0, o_q_hgt} >= C_ROWS);
   assign o_sc_cell = cell_at(i_sc_col, i_sc_row);
   assign o_rd_cell = cell_at(i_rd_col, i_rd_row);
   assign w_wr_hgt  = hgt_at(i_wr_col);
   assign w_wr_ok   = ({1'b0, w_wr_hgt} < C_ROWS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < COLS; c++) begin
            r_hgt[c] <= '0;
            for (int r = 0; r < ROWS; r++) r_cell[c][r] <= CELL_EMPTY;
         end
      end else if (i_clear) begin
         for (int c = 0; c < COLS; c++) begin
            r_hgt[c] <= '0;
            for (int r = 0; r < ROWS; r++) r_cell[c][r] <= CELL_EMPTY;
         end
      end else if (i_wr_en && w_wr_ok) begin
         r_cell[i_wr_col][w_wr_hgt] <= i_wr_code;
         r_hgt[i_wr_col]            <= w_wr_hgt + 3'd1;
      end
   end

endmodule

// File: rtl/drop_controller.sv
// Connect4 move sequencer: validate, drop, sequential four-in-a-row scan, report.
// Optional idle turn forfeit is built when MOVE_TIMEOUT_EN is defined.
module drop_controller
   import connect4_pkg::*;
#(
   parameter int COLS           = 7,
   parameter int ROWS           = 6,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [2:0] move_col,
   output logic       move_ready,
   output logic       reject,
   output logic       turn,
   output logic       result_valid,
   output logic [1:0] result,
   output logic       game_over,
`ifdef MOVE_TIMEOUT_EN
   output logic       timeout,
`endif
   input  logic [2:0] rd_col,
   input  logic [2:0] rd_row,
   output logic [1:0] rd_cell
);
   localparam logic signed [4:0] C_COLS  = 5'(COLS);
   localparam logic signed [4:0] C_ROWS  = 5'(ROWS);
   localparam logic [5:0]        C_CELLS = 6'(COLS * ROWS);

   state_t     r_state, w_next;
   logic [2:0] r_col, r_row;
   logic [5:0] r_cnt;
   logic       r_turn, r_over, r_reject;
   logic [1:0] r_result;
   logic [1:0] r_dir;
   logic       r_side;
   logic [1:0] r_k;
   logic [2:0] r_run;

   logic              w_hs, w_full, w_inb, w_match, w_win, w_side_end, w_scan_end;
   logic [2:0]        w_hgt;
   logic [1:0]        w_code, w_sc_cell;
   logic signed [4:0] w_step, w_pc, w_pr;

`ifdef MOVE_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_tcnt;
   logic        r_timeout;
   assign timeout = r_timeout;
`endif

   assign move_ready   = (r_state == S_IDLE) && !r_over;
   assign w_hs         = move_valid && move_ready && !new_game;
   assign w_code       = player_code(r_turn);
   assign reject       = r_reject;
   assign turn         = r_turn;
   assign result       = r_result;
   assign game_over    = r_over;
   assign result_valid = (r_state == S_REPORT) && !new_game;

   connect4_board #(.COLS(COLS), .ROWS(ROWS)) u_board (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (new_game),
      .i_q_col   (move_col),
      .o_q_hgt   (w_hgt),
      .o_q_full  (w_full),
      .i_wr_en   (r_state == S_PLACE),
      .i_wr_col  (r_col),
      .i_wr_code (w_code),
      .i_sc_col  (w_pc[2:0]),
      .i_sc_row  (w_pr[2:0]),
      .o_sc_cell (w_sc_cell),
      .i_rd_col  (rd_col),
      .i_rd_row  (rd_row),
      .o_rd_cell (rd_cell)
   );

   // Probe address is origin + k*delta, with k negated on the minus side.
   always_comb begin
      w_step     = r_side ? -$signed({3'b000, r_k}) : $signed({3'b000, r_k});
      w_pc       = $signed({2'b00, r_col}) + dir_dc(r_dir) * w_step;
      w_pr       = $signed({2'b00, r_row}) + dir_dr(r_dir) * w_step;
      w_inb      = !w_pc[4] && (w_pc < C_COLS) && !w_pr[4] && (w_pr < C_ROWS);
      w_match    = w_inb && (w_sc_cell == w_code);
      w_win      = w_match && (r_run == 3'd3);
      w_side_end = !w_match || (r_k == 2'd3);
      w_scan_end = w_win || (w_side_end && r_side && (r_dir == DIR_DN));
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_hs && !w_full) w_next = S_PLACE;
         S_PLACE:  w_next = S_SCAN;
         S_SCAN:   if (w_scan_end) w_next = S_REPORT;
         S_REPORT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (new_game) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col    <= '0;
         r_row    <= '0;
         r_cnt    <= '0;
         r_turn   <= 1'b0;
         r_over   <= 1'b0;
         r_reject <= 1'b0;
         r_result <= RES_CONT;
         r_dir    <= DIR_H;
         r_side   <= 1'b0;
         r_k      <= 2'd1;
         r_run    <= 3'd1;
`ifdef MOVE_TIMEOUT_EN
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
`endif
      end else if (new_game) begin
         r_cnt    <= '0;
         r_turn   <= 1'b0;
         r_over   <= 1'b0;
         r_reject <= 1'b0;
         r_result <= RES_CONT;
`ifdef MOVE_TIMEOUT_EN
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         r_reject <= w_hs && w_full;
         if (w_hs) begin
            r_col <= move_col;
            r_row <= w_hgt;
         end
`ifdef MOVE_TIMEOUT_EN
         r_timeout <= 1'b0;
         if ((r_state != S_IDLE) || w_hs || r_over) begin
            r_tcnt <= '0;
         end else if (r_tcnt == TO_LAST) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b1;
            r_turn    <= ~r_turn;
         end else begin
            r_tcnt <= r_tcnt + 32'd1;
         end
`endif
         case (r_state)
            S_PLACE: begin
               r_cnt  <= r_cnt + 6'd1;
               r_dir  <= DIR_H;
               r_side <= 1'b0;
               r_k    <= 2'd1;
               r_run  <= 3'd1;
            end
            S_SCAN: begin
               if (w_scan_end) begin
                  r_result <= w_win ? w_code : ((r_cnt == C_CELLS) ? RES_DRAW : RES_CONT);
               end else if (w_side_end) begin
                  r_k <= 2'd1;
                  if (!r_side) begin
                     r_side <= 1'b1;
                  end else begin
                     r_dir  <= r_dir + 2'd1;
                     r_side <= 1'b0;
                     r_run  <= 3'd1;
                  end
               end else begin
                  r_k   <= r_k + 2'd1;
                  r_run <= r_run + 3'd1;
               end
            end
            S_REPORT: begin
               if (r_result == RES_CONT) r_turn <= ~r_turn;
               else                      r_over <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
